multicycle_ctrl_unit: RTL

- Multi-cycle control FSM for the RV32I core.
- Sits directly upstream of the datapath and drives its full control bundle: register-file write enable, operand selects, PC/RD/WR selects, immediate/load/store/ALU controls.
- Consumes the datapath's b_flag and result back.
- Also sequences the instruction/data memory handshakes, and flags illegal instructions and memory timeouts.

---
 rtl/multicycle_ctrl_unit.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control unit.
// Drives the datapath control bundle, sequences the instruction and data memory
// handshakes, and traps on illegal instructions, misaligned accesses and memory timeouts.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | imem_req high; latch instr into IR on imem_ack
// DECODE | check the IR for legality, then go to EXEC or TRAP
// EXEC   | operand/ALU/imm selects; branches and jumps retire here
// MEM    | data access at address=result; stores retire on dmem_ack
// WB     | register write-back (ALU, LUI, AUIPC, load); retire
// TRAP   | sticky illegal flag; everything idle until rst
module multicycle_ctrl_unit #(
  parameter int unsigned MEM_TIMEOUT      = 16,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        b_flag,
  input  logic [31:0] result,
  output logic        ir_wr_en,
  output logic        pc_wr_en,
  output logic        rf_wr_en,
  output logic        src_1_sel,
  output logic        src_2_sel,
  output logic        addr_align,
  output logic        dst_addr_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  rd_data_sel,
  output logic [1:0]  wr_data_sel,
  output logic [2:0]  imm_sel,
  output logic [2:0]  ld_ctrl,
  output logic [4:0]  s_ctrl,
  output logic [3:0]  alu_ctrl,
  output logic        retire,
  output logic        illegal
);

  // Counter wide enough to hold MEM_TIMEOUT; a 1-bit stub when the timeout is disabled.
  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    ir_q, ir_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd_nz  = (rd != 5'd0);

  // Register-source fields and the upper address bits never influence control.
  logic unused_bits;
  assign unused_bits = ^{ir_q[24:15], result[31:2]};

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, ir_legal;

  // Instruction class and RV32I legality of the latched IR.
  always_comb begin
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_opimm  = 1'b0;
    is_op     = 1'b0;
    ir_legal  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        is_lui   = 1'b1;
        ir_legal = 1'b1;
      end
      OPC_AUIPC: begin
        is_auipc = 1'b1;
        ir_legal = 1'b1;
      end
      OPC_JAL: begin
        is_jal   = 1'b1;
        ir_legal = 1'b1;
      end
      OPC_JALR: begin
        is_jalr  = 1'b1;
        ir_legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        ir_legal  = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        is_load  = 1'b1;
        ir_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        is_store = 1'b1;
        ir_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_OPIMM: begin
        is_opimm = 1'b1;
        // Shift-immediates carry funct7 in the upper immediate bits.
        case (funct3)
          3'b001:  ir_legal = (funct7 == 7'b0000000);
          3'b101:  ir_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: ir_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        is_op    = 1'b1;
        ir_legal = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      default: ir_legal = 1'b0;
    endcase
  end

  logic misaligned, mem_trap;
  logic imem_req_act, dmem_req_act, req_any, ack_any, tmo_hit;

  // Alignment check on the effective address for the current access size.
  always_comb begin
    misaligned = ((funct3[1:0] == 2'b10) && (result[1:0] != 2'b00)) ||
                 ((funct3[1:0] == 2'b01) && result[0]);
    mem_trap   = misaligned && !ALLOW_MISALIGNED;
  end

  // Request/ack qualification; an ack with no request outstanding is ignored.
  always_comb begin
    imem_req_act = (state_q == S_FETCH);
    dmem_req_act = (state_q == S_MEM) && !mem_trap;
    req_any      = imem_req_act || dmem_req_act;
    ack_any      = (imem_req_act && imem_ack) || (dmem_req_act && dmem_ack);
    tmo_hit      = (MEM_TIMEOUT != 0) && req_any && !ack_any &&
                   ((tmo_q + TW'(1)) == TMO_LIMIT);
  end

  // Next-state, IR capture, timeout count and sticky trap flag.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = ir_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch || is_jal || is_jalr)  state_d = S_FETCH;
        else if (is_load || is_store)        state_d = S_MEM;
        else                                 state_d = S_WB;
      end
      S_MEM: begin
        if (mem_trap)       state_d = S_TRAP;
        else if (dmem_ack)  state_d = is_load ? S_WB : S_FETCH;
        else if (tmo_hit)   state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if ((state_d != state_q) || ack_any || !req_any) tmo_d = '0;
    else if (MEM_TIMEOUT != 0)                       tmo_d = tmo_q + TW'(1);
    else                                             tmo_d = tmo_q;

    illegal_d = illegal_q || (state_d == S_TRAP);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
    end
  end

  // Control outputs from state + IR; everything is forced low while rst is high.
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_wr_en     = 1'b0;
    pc_wr_en     = 1'b0;
    rf_wr_en     = 1'b0;
    src_1_sel    = 1'b0;
    src_2_sel    = 1'b0;
    addr_align   = 1'b0;
    dst_addr_sel = 1'b0;
    pc_sel       = 2'b00;
    rd_data_sel  = 2'b00;
    wr_data_sel  = 2'b00;
    imm_sel      = IMM_I;
    ld_ctrl      = 3'b000;
    s_ctrl       = 5'b00000;
    alu_ctrl     = 4'b0000;
    retire       = 1'b0;
    illegal      = illegal_q && !rst;

    if (!rst) begin
      // Operand/ALU/imm selects are held from EXEC through WB so result stays stable.
      if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
        src_1_sel = is_auipc;
        src_2_sel = is_opimm || is_load || is_store || is_jalr || is_auipc || is_lui;
        if (is_store)                   imm_sel = IMM_S;
        else if (is_branch)             imm_sel = IMM_B;
        else if (is_lui || is_auipc)    imm_sel = IMM_U;
        else if (is_jal)                imm_sel = IMM_J;
        else                            imm_sel = IMM_I;
        if (is_op)           alu_ctrl = {funct7[5], funct3};
        else if (is_opimm)   alu_ctrl = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        else if (is_branch)  alu_ctrl = 4'b0001;
        else                 alu_ctrl = 4'b0000;
        if (is_load || is_branch) ld_ctrl = funct3;
      end

      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr_en = imem_ack;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_wr_en = 1'b1;
            pc_sel   = b_flag ? 2'b01 : 2'b00;
            retire   = 1'b1;
          end else if (is_jal || is_jalr) begin
            rf_wr_en    = rd_nz;
            rd_data_sel = 2'b10;
            pc_wr_en    = 1'b1;
            pc_sel      = is_jal ? 2'b01 : 2'b10;
            retire      = 1'b1;
          end
        end
        S_MEM: begin
          if (!mem_trap) begin
            dmem_req     = 1'b1;
            dmem_we      = is_store;
            addr_align   = 1'b1;
            dst_addr_sel = 1'b1;
            if (is_store) begin
              s_ctrl      = {1'b1, 1'b0, funct3};
              wr_data_sel = funct3[1:0];
              if (dmem_ack) begin
                pc_wr_en = 1'b1;
                pc_sel   = 2'b00;
                retire   = 1'b1;
              end
            end
          end
        end
        S_WB: begin
          rf_wr_en = rd_nz;
          pc_wr_en = 1'b1;
          pc_sel   = 2'b00;
          retire   = 1'b1;
          if (is_load)      rd_data_sel = 2'b01;
          else if (is_lui)  rd_data_sel = 2'b11;
          else              rd_data_sel = 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
